tc_program_fetch8: RTL and testbench

Instruction fetch unit that reads the registered 8-bit program memory one byte per cycle and assembles multi-byte instruction words for the core. It drives the memory address, captures returned bytes, and presents completed instructions through a valid/ready handshake. It also accepts redirects (jumps). It sits between the program ROM (1-cycle registered read, data for the address presented at edge N appears after edge N+1) and the decode stage.

---
 rtl/tc_program_fetch8.sv | 116 +++++++++++
 tb/tb_tc_program_fetch8.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tc_program_fetch8.sv
`default_nettype none
// ============================================================================
// tc_program_fetch8 : byte-serial instruction fetch with valid/ready output
// Build option: TC_FETCH8_LITTLE_ENDIAN_EN selects little-endian byte lanes.
// Revision: 1.0
// ============================================================================
module tc_program_fetch8 #(
  parameter int INSTR_BYTES = 4,
  parameter int ADDR_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [7:0]               mem_data,
  input  logic                     jump_valid,
  input  logic [ADDR_W-1:0]        jump_target,
  output logic                     instr_valid,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready
);

  localparam int CNT_W = $clog2(INSTR_BYTES + 1);
  localparam logic [CNT_W-1:0] c_NUM_BYTES = CNT_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] c_LAST_LANE = CNT_W'(INSTR_BYTES - 1);

  localparam logic [0:0] c_ST_FILL = 1'b0;
  localparam logic [0:0] c_ST_OUT  = 1'b1;

  logic [0:0]               r_state;
  logic [ADDR_W-1:0]        r_fptr;
  logic [ADDR_W-1:0]        r_base;
  logic [CNT_W-1:0]         r_issue_cnt;
  logic [CNT_W-1:0]         r_cap_cnt;
  logic                     r_pend;
  logic [8*INSTR_BYTES-1:0] r_buf;
  logic                     r_instr_valid;
  logic [8*INSTR_BYTES-1:0] r_instr;
  logic [ADDR_W-1:0]        r_instr_pc;

  logic                     w_hs;
  logic                     w_issue;
  logic [8*INSTR_BYTES-1:0] w_word;

  assign w_hs    = (r_state == c_ST_OUT) && r_instr_valid && instr_ready;
  assign w_issue = ((r_state == c_ST_FILL) && (r_issue_cnt < c_NUM_BYTES)) || w_hs;

  // Partial word with the byte arriving this cycle merged into its lane.
  always_comb begin
    w_word = r_buf;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      if (r_cap_cnt == CNT_W'(k)) begin
`ifdef TC_FETCH8_LITTLE_ENDIAN_EN
        w_word[8*k +: 8] = mem_data;
`else
        w_word[8*(INSTR_BYTES-1-k) +: 8] = mem_data;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= c_ST_FILL;
      r_fptr        <= '0;
      r_base        <= '0;
      r_issue_cnt   <= '0;
      r_cap_cnt     <= '0;
      r_pend        <= 1'b0;
      r_buf         <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else if (jump_valid) begin
      // Redirect wins; a byte still in flight is dropped by clearing pend.
      r_state       <= c_ST_FILL;
      r_fptr        <= jump_target;
      r_base        <= jump_target;
      r_issue_cnt   <= '0;
      r_cap_cnt     <= '0;
      r_pend        <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_issue) begin
        r_fptr      <= r_fptr + ADDR_W'(1);
        r_pend      <= 1'b1;
        r_issue_cnt <= w_hs ? CNT_W'(1) : r_issue_cnt + CNT_W'(1);
      end else begin
        r_pend      <= 1'b0;
      end

      if (w_hs) begin
        r_base        <= r_fptr;
        r_cap_cnt     <= '0;
        r_state       <= c_ST_FILL;
        r_instr_valid <= 1'b0;
      end else if (r_pend) begin
        r_buf     <= w_word;
        r_cap_cnt <= r_cap_cnt + CNT_W'(1);
        if (r_cap_cnt == c_LAST_LANE) begin
          r_state       <= c_ST_OUT;
          r_instr_valid <= 1'b1;
          r_instr       <= w_word;
          r_instr_pc    <= r_base;
        end
      end
    end
  end

  assign mem_addr    = r_fptr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_tc_program_fetch8.sv
`default_nettype none
// Directed bench for tc_program_fetch8 with a registered ROM holding mem[i]=i[7:0].
module tb_tc_program_fetch8;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int tests_run;
  int tests_failed;

  tc_program_fetch8 #(.INSTR_BYTES(4), .ADDR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) mem_data <= mem_addr[7:0];

  function automatic logic [31:0] exp_word(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
`ifdef TC_FETCH8_LITTLE_ENDIAN_EN
    return {b3, b2, b1, b};
`else
    return {b, b1, b2, b3};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; jump_valid = 1'b0; jump_target = '0; instr_ready = 1'b1;
    tick(); tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests_run++;
    if (instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 0", instr); end
    tests_run++;
    if ({instr_pc, mem_addr} !== 32'h0) begin tests_failed++; $display("FAIL reset_pc_addr: got pc=%h addr=%h want 0/0", instr_pc, mem_addr); end
  endtask

  task automatic test_cold_start();
    rst = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL cold_early: valid=%b want 0 after edge 4", instr_valid); end
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h00), 16'h0000})
      begin tests_failed++; $display("FAIL cold_first: got v=%b i=%h pc=%h want 1 %h 0000", instr_valid, instr, instr_pc, exp_word(8'h00)); end
    tick();
    tests_run++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h0005})
      begin tests_failed++; $display("FAIL cold_hs: got v=%b addr=%h want 0 0005", instr_valid, mem_addr); end
    repeat (3) tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_early: valid=%b want 0", instr_valid); end
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h04), 16'h0004})
      begin tests_failed++; $display("FAIL b2b_second: got v=%b i=%h pc=%h want 1 %h 0004", instr_valid, instr, instr_pc, exp_word(8'h04)); end
  endtask

  task automatic test_ready_hold();
    instr_ready = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (5) tick();
    tests_run++;
    if ({instr_valid, instr, mem_addr} !== {1'b1, exp_word(8'h00), 16'h0004})
      begin tests_failed++; $display("FAIL hold_first: got v=%b i=%h addr=%h want 1 %h 0004", instr_valid, instr, mem_addr, exp_word(8'h00)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({instr_valid, instr, instr_pc, mem_addr} !== {1'b1, exp_word(8'h00), 16'h0000, 16'h0004})
        begin tests_failed++; $display("FAIL hold_stable[%0d]: got v=%b i=%h pc=%h addr=%h", i, instr_valid, instr, instr_pc, mem_addr); end
    end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    tests_run++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h0005})
      begin tests_failed++; $display("FAIL hold_hs: got v=%b addr=%h want 0 0005", instr_valid, mem_addr); end
    repeat (4) tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc, mem_addr} !== {1'b1, exp_word(8'h04), 16'h0004, 16'h0008})
      begin tests_failed++; $display("FAIL hold_next: got v=%b i=%h pc=%h addr=%h", instr_valid, instr, instr_pc, mem_addr); end
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h04), 16'h0004})
      begin tests_failed++; $display("FAIL hold_single_hs: got v=%b i=%h pc=%h", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_jump_discard();
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    tick(); tick();
    jump_valid = 1'b1; jump_target = 16'h0040;
    tick();
    jump_valid = 1'b0;
    tests_run++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h0040})
      begin tests_failed++; $display("FAIL jump_redirect: got v=%b addr=%h want 0 0040", instr_valid, mem_addr); end
    repeat (4) tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL jump_early: valid=%b want 0", instr_valid); end
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h40), 16'h0040})
      begin tests_failed++; $display("FAIL jump_word: got v=%b i=%h pc=%h want 1 %h 0040", instr_valid, instr, instr_pc, exp_word(8'h40)); end
  endtask

  task automatic test_jump_on_handshake();
    instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 16'h0080;
    tick();
    instr_ready = 1'b0; jump_valid = 1'b0;
    tests_run++;
    if ({instr_valid, mem_addr} !== {1'b0, 16'h0080})
      begin tests_failed++; $display("FAIL jump_hs_redirect: got v=%b addr=%h want 0 0080", instr_valid, mem_addr); end
    repeat (5) tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h80), 16'h0080})
      begin tests_failed++; $display("FAIL jump_hs_word: got v=%b i=%h pc=%h want 1 %h 0080", instr_valid, instr, instr_pc, exp_word(8'h80)); end
  endtask

  task automatic test_wrap();
    jump_valid = 1'b1; jump_target = 16'hFFFE;
    tick();
    jump_valid = 1'b0;
    repeat (5) tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc, mem_addr} !== {1'b1, exp_word(8'hFE), 16'hFFFE, 16'h0002})
      begin tests_failed++; $display("FAIL wrap_word: got v=%b i=%h pc=%h addr=%h want 1 %h fffe 0002", instr_valid, instr, instr_pc, mem_addr, exp_word(8'hFE)); end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    repeat (4) tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h02), 16'h0002})
      begin tests_failed++; $display("FAIL wrap_next: got v=%b i=%h pc=%h want 1 %h 0002", instr_valid, instr, instr_pc, exp_word(8'h02)); end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({instr_valid, mem_addr, instr} !== {1'b0, 16'h0000, 32'h0})
      begin tests_failed++; $display("FAIL async_rst: got v=%b addr=%h i=%h want 0 0000 0", instr_valid, mem_addr, instr); end
    tick();
    rst = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL async_early: valid=%b want 0", instr_valid); end
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, exp_word(8'h00), 16'h0000})
      begin tests_failed++; $display("FAIL async_restart: got v=%b i=%h pc=%h want 1 %h 0000", instr_valid, instr, instr_pc, exp_word(8'h00)); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    jump_valid   = 1'b0;
    jump_target  = '0;
    instr_ready  = 1'b0;
    test_reset();
    test_cold_start();
    test_ready_hold();
    test_jump_discard();
    test_jump_on_handshake();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
